// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-word packing, bubble encoding and
// the WB->ID write-through match used when ID/EX captures register data.
package riscv_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CTRL_W   = 12;

  // id_ctrl / ex_ctrl packing:
  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op[3:0], pc_src}
  localparam int CTRL_REG_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 10;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_OP_HI  = 4;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_PC_SRC     = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [4:0]        reg_addr_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // x0 is hard-wired to zero, so a WB write to x0 must never be bypassed.
  function automatic logic wb_hits(input logic wb_we, input reg_addr_t wb_rd,
                                   input reg_addr_t rs_addr);
    return wb_we && (wb_rd != 5'd0) && (wb_rd == rs_addr);
  endfunction

endpackage

// File: rtl/riscv_load_use_detect.sv
// Combinational load-use hazard check: the load sitting in EX produces a
// register that the instruction in ID actually reads.
module riscv_load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic      ex_valid,
  input  logic      ex_mem_read,
  input  reg_addr_t ex_rd_addr,
  input  logic      id_valid,
  input  reg_addr_t id_rs1_addr,
  input  reg_addr_t id_rs2_addr,
  input  logic      id_uses_rs1,
  input  logic      id_uses_rs2,
  output logic      load_use
);

  logic rs1_match;
  logic rs2_match;

  always_comb begin
    rs1_match = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    rs2_match = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    load_use  = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) && id_valid &&
                (rs1_match || rs2_match);
  end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, global hold,
// WB->ID write-through on capture and a bubble performance counter.
module riscv_id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rd_addr,
  input  logic [11:0]      id_ctrl,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic [11:0]      ex_ctrl,
  output logic             ex_mem_read,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Flow control: id_valid marks a real instruction in ID; stall_if_id is the
  // backpressure to IF and IF/ID. While stalled, ID re-presents the same
  // instruction and this stage loads a bubble instead of capturing it.
  // hold freezes this stage outright and is not folded into stall_if_id.

  logic             ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
  logic [4:0]       ex_rs1_addr_q, ex_rs1_addr_d;
  logic [4:0]       ex_rs2_addr_q, ex_rs2_addr_d;
  logic [4:0]       ex_rd_addr_q,  ex_rd_addr_d;
  ctrl_t            ex_ctrl_q,     ex_ctrl_d;
  logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;
  logic             load_use;

  riscv_load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q[CTRL_MEM_READ]),
    .ex_rd_addr  (ex_rd_addr_q),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  // A flush already kills the dependent instruction, so no stall is needed.
  assign stall_if_id = load_use & ~flush & ~rst;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_addr_d = ex_rs1_addr_q;
    ex_rs2_addr_d = ex_rs2_addr_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_ctrl_d     = ex_ctrl_q;
    bubble_cnt_d  = bubble_cnt_q;
    if (!hold) begin
      if (flush || load_use) begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_rs1_addr_d = '0;
        ex_rs2_addr_d = '0;
        ex_rd_addr_d  = '0;
        ex_ctrl_d     = BUBBLE_CTRL;
        bubble_cnt_d  = bubble_cnt_q + CNT_ONE;
      end else begin
        ex_valid_d    = id_valid;
        ex_pc_d       = id_pc;
        ex_rs1_data_d = wb_hits(wb_reg_write, wb_rd_addr, id_rs1_addr) ? wb_data : id_rs1_data;
        ex_rs2_data_d = wb_hits(wb_reg_write, wb_rd_addr, id_rs2_addr) ? wb_data : id_rs2_data;
        ex_imm_d      = id_imm;
        ex_rs1_addr_d = id_rs1_addr;
        ex_rs2_addr_d = id_rs2_addr;
        ex_rd_addr_d  = id_rd_addr;
        ex_ctrl_d     = id_valid ? id_ctrl : BUBBLE_CTRL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_ctrl_q     <= BUBBLE_CTRL;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_addr_q <= ex_rs1_addr_d;
      ex_rs2_addr_q <= ex_rs2_addr_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_ctrl_q     <= ex_ctrl_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1_data  = ex_rs1_data_q;
  assign ex_rs2_data  = ex_rs2_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1_addr  = ex_rs1_addr_q;
  assign ex_rs2_addr  = ex_rs2_addr_q;
  assign ex_rd_addr   = ex_rd_addr_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_mem_read  = ex_ctrl_q[CTRL_MEM_READ];
  assign ex_reg_write = ex_ctrl_q[CTRL_REG_WRITE];
  assign bubble_count = bubble_cnt_q;

endmodule

// File: doc/riscv_id_ex_stage.md
Name: riscv_id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX.
- Its ex_rs1_addr/ex_rs2_addr outputs drive the forwarding unit. Its ex_rd_addr/ex_mem_read feed back into its own hazard check.
- Inserts bubbles on load-use hazards and flushes, holds on a global pipeline hold, and applies WB→ID write-through so that captured register data is never stale.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of the bubble performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- hold  in  1  global freeze (memory stall); ID/EX keeps its contents
- flush  in  1  branch/jump redirect from EX; kills the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1_addr, id_rs2_addr  in  5 each  source registers
- id_uses_rs1, id_uses_rs2  in  1 each  the instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_rd_addr  in  5  destination register
- id_ctrl  in  12  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op[3:0], pc_src}
- wb_reg_write  in  1  WB write enable
- wb_rd_addr  in  5  WB destination
- wb_data  in  XLEN  WB write data
- stall_if_id  out  1  IF and IF/ID must hold (load-use)
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered fields
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  registered addresses
- ex_ctrl  out  12  registered control, same packing as id_ctrl
- ex_mem_read, ex_reg_write  out  1 each  decoded views of ex_ctrl
- bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: ex_valid=0, every ex_* field=0, bubble_count=0.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- stall_if_id = load_use & ~flush & ~rst. hold does not mask it; upstream ORs hold in itself.
- Per-edge update priority:
  - rst: clear all state.
  - hold: all registers keep their values; bubble_count unchanged.
  - flush: load a bubble (ex_valid=0, ex_ctrl=0, addresses=0, data fields=0); bubble_count+1.
  - load_use: load a bubble; bubble_count+1.
  - otherwise: capture the ID fields. ex_valid=id_valid. When id_valid=0, ex_ctrl is forced to 0.
- Write-through on capture: if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==id_rs1_addr, ex_rs1_data takes wb_data; otherwise it takes id_rs1_data. rs2 works the same way.
- Invariant: ex_ctrl is all-zero whenever ex_valid=0. ex_reg_write and ex_mem_read are therefore never set by a bubble.
- Latency: 1 cycle from ID to EX. A load-use hazard costs exactly one bubble: on the next cycle the load is in MEM, load_use drops, and the forwarding unit supplies the data.
- bubble_count wraps modulo 2^CNT_W. It is not incremented on a hold cycle even if flush or load_use is asserted.
- flush and load_use in the same cycle: one bubble, one increment, stall_if_id=0.
- rst asserted mid-stream overrides hold and flush. stall_if_id=0 during reset.

Decomposition:
- Shared package riscv_pipe_pkg: XLEN default, CTRL_W=12, ctrl bit-index constants (CTRL_REG_WRITE, CTRL_MEM_READ, ...), BUBBLE_CTRL=0.
- Natural sub-module: riscv_load_use_detect, combinational, computing load_use. The register, write-through and counter stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 → ex_valid=0, ex_ctrl=0, bubble_count=0, stall_if_id=0.
- Load-use: EX holds lw x5 (mem_read=1, rd=5); ID holds add x6,x5,x1 with uses_rs1=1 → stall_if_id=1. Next edge: ex_valid=0, bubble_count=1. Following cycle: stall_if_id=0 and the add captures.
- No false stall: same case but rd=0, or uses_rs1=0, or ex_mem_read=0 → stall_if_id=0 and the add captures directly.
- Write-through: wb_reg_write=1, wb_rd=3, wb_data=0xDEADBEEF, id_rs2_addr=3, id_rs2_data=0x11 → ex_rs2_data=0xDEADBEEF. Repeat with wb_rd=0 → ex_rs2_data=0x11.
- Hold vs flush: hold=1 and flush=1 for 3 cycles → ex_* unchanged, bubble_count unchanged. Release hold with flush=1 → bubble loaded, count +1.
- Simultaneous flush and load_use → one bubble, count +1, stall_if_id=0. Preset bubble_count to 2^CNT_W−1 (CNT_W=4 build), insert a bubble → count wraps to 0.
